// File: rtl/am_dds_mod.sv
// am_dds_mod: two-channel DDS AM source with handshake retune and a 5-stage output pipeline.
// Define AM_DSB_SC_EN to build the suppressed-carrier variant (envelope bias removed).
module am_dds_mod #(
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 8,
    parameter int CAR_W   = 8,
    parameter int MSG_W   = 9,
    parameter int DEPTH_W = 8,
    parameter int OUT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [PHASE_W-1:0]        cfg_car_ftw,
    input  logic [PHASE_W-1:0]        cfg_msg_ftw,
    input  logic [DEPTH_W-1:0]        cfg_depth,
    output logic signed [CAR_W-1:0]   car_out,
    output logic signed [MSG_W-1:0]   msg_out,
    output logic signed [OUT_W-1:0]   am_out,
    output logic                      out_valid
);
    localparam int QW     = LUT_AW - 2;
    localparam int QN     = 1 << QW;
    localparam int ENV_W  = MSG_W + 1;
    localparam int MIX_W  = MSG_W + DEPTH_W + 1;
    localparam int PROD_W = CAR_W + MSG_W + 1;
    localparam int SHIFT  = PROD_W - OUT_W;

    // Quarter-wave cosine sampled at half-index offsets, so the four quadrants
    // mirror cleanly and index 0 holds the positive peak. Integer Taylor series in Q30.
    function automatic longint quarter_cos(input int idx, input int width);
        longint x, x2, term, sum, amp;
        x    = (64'sd3373259426 * longint'(2 * idx + 1)) / longint'(4 * QN);
        x2   = (x * x) >>> 30;
        term = 64'sd1 <<< 30;
        sum  = term;
        for (int k = 1; k <= 8; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k - 1) * (2 * k));
            sum  = sum + term;
        end
        amp = (64'sd1 <<< (width - 1)) - 64'sd1;
        return (amp * sum + (64'sd1 <<< 29)) >>> 30;
    endfunction

    logic [CAR_W-2:0] car_rom [QN];
    logic [MSG_W-2:0] msg_rom [QN];

    generate
        for (genvar gi = 0; gi < QN; gi++) begin : g_rom
            assign car_rom[gi] = (CAR_W-1)'(quarter_cos(gi, CAR_W));
            assign msg_rom[gi] = (MSG_W-1)'(quarter_cos(gi, MSG_W));
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t             state_reg;
    logic               cfg_ready_reg;
    logic [PHASE_W-1:0] car_acc_reg, msg_acc_reg;
    logic [PHASE_W-1:0] car_ftw_reg, msg_ftw_reg;
    logic [PHASE_W-1:0] car_ftw_shd_reg, msg_ftw_shd_reg;
    logic [DEPTH_W-1:0] depth_reg, depth_shd_reg;
    logic [PHASE_W:0]   car_sum;
    logic               car_wrap;
    logic               cfg_accept;

    assign cfg_ready  = cfg_ready_reg;
    assign cfg_accept = cfg_valid & cfg_ready_reg;
    assign car_sum    = {1'b0, car_acc_reg} + {1'b0, car_ftw_reg};
    assign car_wrap   = car_sum[PHASE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cfg_ready_reg   <= 1'b0;
            car_acc_reg     <= '0;
            msg_acc_reg     <= '0;
            car_ftw_reg     <= '0;
            msg_ftw_reg     <= '0;
            depth_reg       <= '0;
            car_ftw_shd_reg <= '0;
            msg_ftw_shd_reg <= '0;
            depth_shd_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    car_acc_reg   <= '0;
                    msg_acc_reg   <= '0;
                    cfg_ready_reg <= 1'b1;
                    if (cfg_accept) begin
                        car_ftw_reg <= cfg_car_ftw;
                        msg_ftw_reg <= cfg_msg_ftw;
                        depth_reg   <= cfg_depth;
                    end
                    if (run) state_reg <= RUN;
                end
                RUN: begin
                    if (!run) begin
                        state_reg     <= IDLE;
                        car_acc_reg   <= '0;
                        msg_acc_reg   <= '0;
                        cfg_ready_reg <= 1'b1;
                        if (cfg_accept) begin
                            car_ftw_reg <= cfg_car_ftw;
                            msg_ftw_reg <= cfg_msg_ftw;
                            depth_reg   <= cfg_depth;
                        end
                    end else begin
                        car_acc_reg <= car_sum[PHASE_W-1:0];
                        msg_acc_reg <= msg_acc_reg + msg_ftw_reg;
                        if (cfg_accept) begin
                            car_ftw_shd_reg <= cfg_car_ftw;
                            msg_ftw_shd_reg <= cfg_msg_ftw;
                            depth_shd_reg   <= cfg_depth;
                            cfg_ready_reg   <= 1'b0;
                            state_reg       <= PEND;
                        end
                    end
                end
                PEND: begin
                    if (!run) begin
                        state_reg     <= IDLE;
                        car_acc_reg   <= '0;
                        msg_acc_reg   <= '0;
                        cfg_ready_reg <= 1'b1;
                        car_ftw_reg   <= car_ftw_shd_reg;
                        msg_ftw_reg   <= msg_ftw_shd_reg;
                        depth_reg     <= depth_shd_reg;
                    end else begin
                        car_acc_reg <= car_sum[PHASE_W-1:0];
                        msg_acc_reg <= msg_acc_reg + msg_ftw_reg;
                        // Swap at the carrier wrap: the phase is near zero, so no visible step.
                        if (car_wrap) begin
                            car_ftw_reg   <= car_ftw_shd_reg;
                            msg_ftw_reg   <= msg_ftw_shd_reg;
                            depth_reg     <= depth_shd_reg;
                            cfg_ready_reg <= 1'b1;
                            state_reg     <= RUN;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    cfg_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // Sample pipeline; depth travels with each sample so a change never splits one.
    logic [LUT_AW-1:0]        car_ph_s1_reg, msg_ph_s1_reg;
    logic [QW-1:0]            car_addr_s2_reg, msg_addr_s2_reg;
    logic                     car_neg_s2_reg, msg_neg_s2_reg;
    logic signed [CAR_W-1:0]  car_s3_reg, car_s4_reg;
    logic signed [MSG_W-1:0]  msg_s3_reg, msg_s4_reg;
    logic [DEPTH_W-1:0]       depth_s1_reg, depth_s2_reg, depth_s3_reg;
    logic signed [ENV_W-1:0]  scaled_s4_reg;
    logic [3:0]               valid_reg;

    logic signed [MIX_W-1:0]  mix_prod;
    logic signed [ENV_W-1:0]  env;
    logic signed [PROD_W-1:0] am_prod;

`ifndef AM_DSB_SC_EN
    localparam logic signed [ENV_W-1:0] ENV_BIAS = ENV_W'(2 ** (MSG_W - 1));
`endif

    always_comb begin
        mix_prod = msg_s3_reg * $signed({1'b0, depth_s3_reg});
`ifdef AM_DSB_SC_EN
        env = scaled_s4_reg;
`else
        env = ENV_BIAS + scaled_s4_reg;
`endif
        am_prod = car_s4_reg * env;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_ph_s1_reg   <= '0;
            msg_ph_s1_reg   <= '0;
            depth_s1_reg    <= '0;
            car_addr_s2_reg <= '0;
            msg_addr_s2_reg <= '0;
            car_neg_s2_reg  <= 1'b0;
            msg_neg_s2_reg  <= 1'b0;
            depth_s2_reg    <= '0;
            car_s3_reg      <= '0;
            msg_s3_reg      <= '0;
            depth_s3_reg    <= '0;
            car_s4_reg      <= '0;
            msg_s4_reg      <= '0;
            scaled_s4_reg   <= '0;
            valid_reg       <= '0;
            car_out         <= '0;
            msg_out         <= '0;
            am_out          <= '0;
            out_valid       <= 1'b0;
        end else begin
            car_ph_s1_reg <= car_acc_reg[PHASE_W-1 -: LUT_AW];
            msg_ph_s1_reg <= msg_acc_reg[PHASE_W-1 -: LUT_AW];
            depth_s1_reg  <= depth_reg;

            car_addr_s2_reg <= car_ph_s1_reg[LUT_AW-2] ? ~car_ph_s1_reg[QW-1:0] : car_ph_s1_reg[QW-1:0];
            msg_addr_s2_reg <= msg_ph_s1_reg[LUT_AW-2] ? ~msg_ph_s1_reg[QW-1:0] : msg_ph_s1_reg[QW-1:0];
            car_neg_s2_reg  <= car_ph_s1_reg[LUT_AW-1] ^ car_ph_s1_reg[LUT_AW-2];
            msg_neg_s2_reg  <= msg_ph_s1_reg[LUT_AW-1] ^ msg_ph_s1_reg[LUT_AW-2];
            depth_s2_reg    <= depth_s1_reg;

            car_s3_reg   <= car_neg_s2_reg ? -$signed({1'b0, car_rom[car_addr_s2_reg]})
                                           :  $signed({1'b0, car_rom[car_addr_s2_reg]});
            msg_s3_reg   <= msg_neg_s2_reg ? -$signed({1'b0, msg_rom[msg_addr_s2_reg]})
                                           :  $signed({1'b0, msg_rom[msg_addr_s2_reg]});
            depth_s3_reg <= depth_s2_reg;

            car_s4_reg    <= car_s3_reg;
            msg_s4_reg    <= msg_s3_reg;
            scaled_s4_reg <= ENV_W'(mix_prod >>> DEPTH_W);

            valid_reg <= {valid_reg[2:0], (state_reg != IDLE)};
            out_valid <= valid_reg[3];
            if (valid_reg[3]) begin
                car_out <= car_s4_reg;
                msg_out <= msg_s4_reg;
                am_out  <= OUT_W'(am_prod >>> SHIFT);
            end
        end
    end
endmodule

// File: tb/tb_am_dds_mod.sv
// Directed bench for am_dds_mod: reset, latency, depth, retune, drain; build with AM_DSB_SC_EN for the DSB-SC variant.
module tb_am_dds_mod;
    logic               clk = 1'b0;
    logic               rst_n, run, cfg_valid, cfg_ready, out_valid;
    logic [23:0]        cfg_car_ftw, cfg_msg_ftw;
    logic [7:0]         cfg_depth;
    logic signed [7:0]  car_out;
    logic signed [8:0]  msg_out;
    logic signed [15:0] am_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    am_dds_mod dut (
        .clk(clk), .rst_n(rst_n), .run(run), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_car_ftw(cfg_car_ftw), .cfg_msg_ftw(cfg_msg_ftw), .cfg_depth(cfg_depth),
        .car_out(car_out), .msg_out(msg_out), .am_out(am_out), .out_valid(out_valid)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
            $display("  ok   %-16s got=%0d", tag, got);
        end else begin
            $display("FAIL %-16s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_am(input int car, input int msg, input int d);
        int sc;
        sc = (msg * d) >>> 8;
`ifdef AM_DSB_SC_EN
        return (car * sc) >>> 2;
`else
        return (car * (256 + sc)) >>> 2;
`endif
    endfunction

    // Runs n samples; reports carrier/message rising-crossing interval range, largest carrier step and model mismatches.
    task automatic run_window(input int n, input int d, output int c_min, output int c_max,
                              output int m_min, output int m_max, output int max_step, output int bad);
        int c_last, m_last, c_prev, m_prev, step;
        c_min = 1 << 30; c_max = 0; m_min = 1 << 30; m_max = 0; max_step = 0; bad = 0;
        c_last = -1; m_last = -1;
        c_prev = int'(car_out);
        m_prev = int'(msg_out);
        for (int i = 1; i <= n; i++) begin
            tick();
            if (!out_valid || int'(am_out) != model_am(int'(car_out), int'(msg_out), d)) bad++;
`ifndef AM_DSB_SC_EN
            if ((car_out > 0 && am_out < 0) || (car_out < 0 && am_out >= 0)) bad++;
`endif
            step = int'(car_out) - c_prev;
            if (step < 0) step = -step;
            if (step > max_step) max_step = step;
            if (c_prev < 0 && car_out > 0) begin
                if (c_last >= 0) begin
                    if (i - c_last < c_min) c_min = i - c_last;
                    if (i - c_last > c_max) c_max = i - c_last;
                end
                c_last = i;
            end
            if (m_prev < 0 && msg_out > 0) begin
                if (m_last >= 0) begin
                    if (i - m_last < m_min) m_min = i - m_last;
                    if (i - m_last > m_max) m_max = i - m_last;
                end
                m_last = i;
            end
            c_prev = int'(car_out);
            m_prev = int'(msg_out);
        end
    endtask

    initial begin
        int cmin, cmax, mmin, mmax, mstep, bad, bad2, len, mstep2;
        logic signed [15:0] hold_am;
        logic signed [7:0]  hold_car;

        rst_n = 1'b0; run = 1'b0; cfg_valid = 1'b0;
        cfg_car_ftw = '0; cfg_msg_ftw = '0; cfg_depth = '0;
        #23;
        check("rst_ready", cfg_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_am", am_out, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ready_release", cfg_ready, 1);
        repeat (3) tick();
        check("idle_no_valid", out_valid, 0);

        // Config offered in the same cycle run rises.
        cfg_car_ftw = 24'd167772; cfg_msg_ftw = 24'd16777; cfg_depth = 8'd0;
        cfg_valid = 1'b1; run = 1'b1;
        tick();
        cfg_valid = 1'b0;
        repeat (4) tick();
        check("lat_pre", out_valid, 0);
        tick();
        check("lat_rise", out_valid, 1);
        check("lat_car", car_out, 127);
        check("lat_msg", msg_out, 255);
        check("lat_am", am_out, 8128);
        run_window(2100, 0, cmin, cmax, mmin, mmax, mstep, bad);
        check("d0_model_bad", bad, 0);
        check("car_period_100", (cmin >= 99 && cmax <= 101), 1);
        check("msg_period_1000", (mmin >= 999 && mmax <= 1001), 1);

        // Stop with a depth change offered on the same cycle; drain timing.
        cfg_depth = 8'd255; cfg_valid = 1'b1; run = 1'b0;
        tick();
        cfg_valid = 1'b0;
        repeat (4) tick();
        check("drain_pre", out_valid, 1);
        tick();
        check("drain_fall", out_valid, 0);

        run = 1'b1;
        repeat (6) tick();
        check("fd_valid", out_valid, 1);
        check("fd_car_peak", car_out, 127);
        check("fd_msg_peak", msg_out, 255);
`ifdef AM_DSB_SC_EN
        check("dsb_am_peak", am_out, 8064);
`else
        check("fd_am_peak", am_out, 16192);
`endif
        run_window(500, 255, cmin, cmax, mmin, mmax, mstep, bad);
        check("fd_car_t", car_out, 127);
        check("fd_msg_trough", msg_out, -255);
`ifdef AM_DSB_SC_EN
        check("dsb_am_trough", am_out, -8097);
`else
        check("fd_am_trough", am_out, 31);
`endif
        run_window(1300, 255, cmin, cmax, mmin, mmax, mstep, bad2);
        check("fd_model_bad", bad + bad2, 0);
        check("fd_msg_period", (mmin >= 999 && mmax <= 1001), 1);

        // Back to depth 0, then retune the carrier while running.
        cfg_depth = 8'd0; cfg_valid = 1'b1; run = 1'b0;
        tick();
        cfg_valid = 1'b0;
        repeat (5) tick();
        run = 1'b1;
        repeat (6) tick();
`ifdef AM_DSB_SC_EN
        check("dsb_zero_msg", am_out, 0);
`endif
        run_window(30, 0, cmin, cmax, mmin, mmax, mstep, bad);
        cfg_car_ftw = 24'd335544; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("retune_ready_low", cfg_ready, 0);
        len = 0;
        while (!cfg_ready && len < 200) begin
            tick();
            len++;
        end
        $display("  info pend cycles=%0d", len);
        check("retune_pend_len", (len >= 1 && len <= 101), 1);
        run_window(12, 0, cmin, cmax, mmin, mmax, mstep, bad);
        run_window(200, 0, cmin, cmax, mmin, mmax, mstep2, bad2);
        check("retune_model_bad", bad + bad2, 0);
        check("retune_step", (mstep <= 20 && mstep2 <= 20), 1);
        check("retune_period_50", (cmin >= 49 && cmax <= 51), 1);

        // Pending config must be applied when run drops during PEND.
        run = 1'b0;
        repeat (6) tick();
        run = 1'b1;
        repeat (6) tick();
        run_window(10, 0, cmin, cmax, mmin, mmax, mstep, bad);
        cfg_car_ftw = 24'd167772; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0; run = 1'b0;
        check("pend_ready_low", cfg_ready, 0);
        repeat (5) tick();
        check("stop_drain_pre", out_valid, 1);
        tick();
        check("stop_drain_fall", out_valid, 0);
        hold_car = car_out;
        hold_am  = am_out;
        repeat (3) tick();
        check("hold_car", car_out, hold_car);
        check("hold_am", am_out, hold_am);
        check("idle_ready", cfg_ready, 1);
        run = 1'b1;
        repeat (6) tick();
        check("restart_car", car_out, 127);
`ifndef AM_DSB_SC_EN
        check("restart_am", am_out, 8128);
`endif
        run_window(250, 0, cmin, cmax, mmin, mmax, mstep, bad);
        check("restart_model_bad", bad, 0);
        check("restart_period", (cmin >= 99 && cmax <= 101), 1);

        // Asynchronous reset in the middle of a run.
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #2;
        check("arst_valid", out_valid, 0);
        check("arst_car", car_out, 0);
        check("arst_msg", msg_out, 0);
        check("arst_am", am_out, 0);
        check("arst_ready", cfg_ready, 0);
        run = 1'b0;
        #500;
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_ready_up", cfg_ready, 1);
        repeat (8) tick();
        check("arst_idle_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/am_dds_mod.md
Name: am_dds_mod

Overview:
Parametrised AM signal source, next generation of the fixed cos_make generator (fixed 100 kHz / 1 MHz cosines).
- Two phase-accumulator DDS channels, carrier and message, each with a run-time frequency tuning word (FTW).
- Run-time modulation depth.
- Glitch-free retune through a valid/ready config handshake.
- Pipelined AM output with an out_valid qualifier, feeding the downstream DAC/AM-demod path.

Parameters:
- PHASE_W, 24: phase accumulator width.
- LUT_AW, 8: phase bits used for LUT addressing. Top 2 bits select the quadrant. The quarter-wave table has 2^(LUT_AW-2) entries.
- CAR_W, 8: signed carrier sample width.
- MSG_W, 9: signed message sample width.
- DEPTH_W, 8: unsigned modulation depth width. Depth = cfg_depth / 2^DEPTH_W.
- OUT_W, 16: signed AM output width. Must be ≤ CAR_W+MSG_W+1.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- run, in, 1: 1 = generate, 0 = stop and drain.
- cfg_valid, in, 1: config offer.
- cfg_ready, out, 1: config accept.
- cfg_car_ftw, in, PHASE_W: carrier FTW.
- cfg_msg_ftw, in, PHASE_W: message FTW.
- cfg_depth, in, DEPTH_W: modulation depth.
- car_out, out, CAR_W signed: carrier cosine, aligned with am_out.
- msg_out, out, MSG_W signed: message cosine, aligned with am_out.
- am_out, out, OUT_W signed: modulated output.
- out_valid, out, 1: outputs valid.

Behaviour:
- Reset (async, rst_n=0): all of the following clear to 0:
  - accumulators, active FTWs/depth, pipeline, car_out, msg_out, am_out, out_valid.
  - cfg_ready=0; state=IDLE.
  - cfg_ready rises the first cycle after reset release.
- FSM states: IDLE, RUN, PEND.
  - IDLE: accumulators held at 0; cfg_ready=1. An accepted config (cfg_valid & cfg_ready) loads the active registers on the next edge. run=1 -> RUN.
  - RUN: each cycle, acc += car_ftw (mod 2^PHASE_W) and msg_acc += msg_ftw. cfg_ready=1. Accept -> capture into shadow registers, go to PEND.
  - PEND: cfg_ready=0. Shadow registers are copied to active on the cycle the carrier accumulator wraps (carry-out), then return to RUN. Accumulators are not reset, so the phase stays continuous.
  - run=0 in RUN or PEND -> IDLE. Any pending shadow config is applied on entry to IDLE. Accumulators are cleared.
  - cfg_valid with run rising in the same cycle: config is accepted and applied in IDLE first; RUN starts using it.
- LUT: phase[PHASE_W-1 -: LUT_AW]. The quadrant mirrors the index and negates the sample.
  - Cosine amplitude is 2^(W-1)-1, i.e. 127 for CAR_W=8 and 255 for MSG_W=9.
  - Phase 0 gives +peak. Phase 2^(PHASE_W-1) gives -peak.
  - No -2^(W-1) code is ever produced.
- Pipeline, 5 stages, registered:
  - S1: phase.
  - S2: quadrant/address.
  - S3: LUT + sign.
  - S4: scaled = (msg*depth) >>> DEPTH_W, arithmetic, MSG_W+1 bits.
  - S5: env = 2^(MSG_W-1) + scaled, always >0; prod = car*env, signed CAR_W+MSG_W+1 bits; am_out = prod >>> (CAR_W+MSG_W+1-OUT_W), truncation toward -inf.
- car_out and msg_out are delayed to align with am_out.
- Latency: out_valid rises exactly 5 cycles after the first RUN cycle. It falls 5 cycles after leaving RUN/PEND, after draining the pipe. While out_valid=0, data outputs hold their last value.
- Depth change takes effect at the S4 stage of the first sample after application; no partial-sample mixing.
- FTW=0: constant output (DC carrier at phase 0, i.e. +peak).

Optional Feature:
AM_DSB_SC_EN
- Defined: suppressed-carrier mode. The env bias is removed, so prod = car*scaled. Output is the same width and shift. The zero message gives am_out=0.
- Undefined: standard AM with the bias 2^(MSG_W-1), as above.

Test Plan:
- Reset:
  - rst_n low for 500 ns mid-RUN -> all outputs 0 immediately (async).
  - cfg_ready=1 one cycle after release.
  - out_valid stays 0 while run=0.
- Latency:
  - Config car_ftw=167772, msg_ftw=16777, depth=0, run=1 at 100 MHz.
  - out_valid high exactly 5 cycles later; first car_out=127, am_out=8128.
  - Carrier period is 100 samples ±1; message period is 1000 ±1.
- Full depth:
  - depth=255.
  - At msg peak +255: am_out = (127*(256+254))>>>2 = 16192.
  - At msg trough -255: env = 256-255 = 1, am_out = 127>>>2 = 31.
  - Envelope never crosses zero.
- Retune:
  - In RUN, offer car_ftw=335544.
  - cfg_ready drops for the PEND period; new frequency starts only after the carrier accumulator wrap.
  - No phase discontinuity: the sample-to-sample step stays ≤ the new FTW.
- Stop/drain:
  - run=0 -> out_valid falls after 5 cycles.
  - Accumulators are 0.
  - A pending config is applied; the next run starts from car_out=127.
- AM_DSB_SC_EN build:
  - depth=255, msg=0 -> am_out=0.
  - msg=+255 -> am_out = (127*254)>>>2 = 8064.
